seq_alu: RTL and testbench
==========================

# seq_alu

Multi-cycle integer execution unit that consumes the 4-bit ALU control code produced by the control unit's ALU decoder. It operates on two operands and returns a registered result plus a Zero flag. Shifts execute serially, one bit per cycle, to save area. The block sits in the execute stage behind a valid/ready handshake on both its input and output sides.

## Interface
- DATA_WIDTH, 32, operand and result width
- ALU_CTRL_WIDTH, 4, width of the ALU control code
- SHAMT_WIDTH, 5, shift amount width, taken from SrcB[SHAMT_WIDTH-1:0]

- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operation offered
- in_ready  output  1  unit can accept an operation this cycle
- ALUControl  input  ALU_CTRL_WIDTH  operation code, sampled on accept
- SrcA  input  DATA_WIDTH  operand A, sampled on accept
- SrcB  input  DATA_WIDTH  operand B, sampled on accept
- out_valid  output  1  ALUResult and Zero are valid
- out_ready  input  1  consumer takes the result
- ALUResult  output  DATA_WIDTH  registered result
- Zero  output  1  ALUResult == 0, registered together with the result

## Operation
- Codes:
  - 0000 add, 0001 sub, 0010 sll, 0011 slt (signed), 0100 sltu, 0101 xor
  - 0110 srl, 0111 sra, 1000 or, 1001 and, 1011 pass SrcB (U/J-type)
  - Every other code (1010, 1100–1111) behaves as add.
- add/sub wrap modulo 2^DATA_WIDTH. slt/sltu return 1 or 0, zero-extended.
- Shift amount is SrcB[4:0]; upper bits of SrcB are ignored. srl fills with 0; sra fills with SrcA[31], the bit captured at accept.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: in_ready=1. On accept (in_valid & in_ready):
    - Non-shift op, or shift with shamt=0: result is computed and registered, and the FSM goes to DONE.
    - Shift with shamt=n>0: the accumulator loads SrcA, the counter loads n, and the FSM goes to SHIFT.
  - SHIFT: each edge shifts the accumulator by 1 bit and decrements the counter. When the counter decrements from 1 to 0, the accumulator holds the final value and the FSM goes to DONE, with Zero computed from the final value. in_ready=0.
  - DONE: out_valid=1.
    - out_ready=1 with in_valid=0: go to IDLE.
    - out_ready=1 with in_valid=1: accept the new op in the same cycle (in_ready=1). Branch as in IDLE.
    - out_ready=0: hold ALUResult/Zero stable, in_ready=0.
- Inputs are ignored whenever in_ready=0.

## Timing
- Reset (asynchronous, takes effect immediately):
  - state IDLE, counter 0
  - out_valid=0, ALUResult=0, Zero=0
  - in_ready=1 after reset deasserts
- Reset asserted mid-shift or in DONE discards the operation; no result is ever produced for it.
- Latency from the accept edge to out_valid high:
  - non-shift ops and shamt=0: 1 cycle
  - shift by n: 1+n cycles (max 32)
- Throughput with out_ready held high:
  - non-shift ops: 1 op/cycle, back-to-back through DONE
  - shifts: one op per 1+n cycles
- out_valid drops the cycle after the consuming edge unless a new single-cycle op was accepted on that same edge.
- in_ready is combinational from state and out_ready only; it never depends on in_valid.

## Test plan
- add 0x7FFFFFFF + 0x00000001, then add 0xFFFFFFFF + 0x00000001 → 0x80000000 with Zero=0, then 0x00000000 with Zero=1. Each result has out_valid one cycle after accept.
- sub 5−5 → 0, Zero=1. slt 0xFFFFFFFF vs 1 → 1. sltu 0xFFFFFFFF vs 1 → 0. Code 1011 with SrcB=0x12345000 → 0x12345000. Code 1111 with 3,4 → 7.
- sra 0x80000000 by SrcB=0xFFFFFFFF (shamt 31) → 0xFFFFFFFF after exactly 32 cycles, with in_ready=0 throughout SHIFT. srl of the same operands → 0x00000001. sll 0x1 by shamt 0 → 0x1 after 1 cycle.
- Back-to-back xor/or/and with out_ready=1 → three results on three consecutive cycles and in_ready continuously 1. Repeat with out_ready=0 for 4 cycles: the result holds stable, in_ready=0, and the next op is accepted only on the edge where out_ready=1.
- Assert rst 3 cycles into a shift by 10 → out_valid=0 and ALUResult=0 immediately. After release, a fresh add 2+3 → 5 with 1-cycle latency.
- Offer in_valid during SHIFT with different operands → they are ignored and the in-flight shift result is unchanged.

Source files
------------

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle integer execution unit for the execute stage.
// Single-cycle ops finish on the accept edge; shifts run serially, one bit
// per cycle, so no barrel shifter is needed. Valid/ready on both sides.
module seq_alu #(
  parameter int DATA_WIDTH     = 32,
  parameter int ALU_CTRL_WIDTH = 4,
  parameter int SHAMT_WIDTH    = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ALU_CTRL_WIDTH-1:0] ALUControl,
  input  logic [DATA_WIDTH-1:0]     SrcA,
  input  logic [DATA_WIDTH-1:0]     SrcB,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     ALUResult,
  output logic                      Zero
);

  localparam logic [ALU_CTRL_WIDTH-1:0] OP_SUB  = ALU_CTRL_WIDTH'(1);
  localparam logic [ALU_CTRL_WIDTH-1:0] OP_SLL  = ALU_CTRL_WIDTH'(2);
  localparam logic [ALU_CTRL_WIDTH-1:0] OP_SLT  = ALU_CTRL_WIDTH'(3);
  localparam logic [ALU_CTRL_WIDTH-1:0] OP_SLTU = ALU_CTRL_WIDTH'(4);
  localparam logic [ALU_CTRL_WIDTH-1:0] OP_XOR  = ALU_CTRL_WIDTH'(5);
  localparam logic [ALU_CTRL_WIDTH-1:0] OP_SRL  = ALU_CTRL_WIDTH'(6);
  localparam logic [ALU_CTRL_WIDTH-1:0] OP_SRA  = ALU_CTRL_WIDTH'(7);
  localparam logic [ALU_CTRL_WIDTH-1:0] OP_OR   = ALU_CTRL_WIDTH'(8);
  localparam logic [ALU_CTRL_WIDTH-1:0] OP_AND  = ALU_CTRL_WIDTH'(9);
  localparam logic [ALU_CTRL_WIDTH-1:0] OP_PASSB = ALU_CTRL_WIDTH'(11);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef enum logic [1:0] {SH_LL, SH_RL, SH_RA} shift_kind_t;

  state_t                  state_q, state_d;
  shift_kind_t             kind_q;
  logic [SHAMT_WIDTH-1:0]  cnt_q;
  logic [DATA_WIDTH-1:0]   res_q;
  logic                    zero_q;
  logic                    fill_q;

  logic [SHAMT_WIDTH-1:0]  shamt;
  logic                    is_shift;
  logic                    accept;
  logic                    start_shift;
  logic [DATA_WIDTH-1:0]   alu_res;
  logic [DATA_WIDTH-1:0]   shift_step;

  assign shamt       = SrcB[SHAMT_WIDTH-1:0];
  assign is_shift    = (ALUControl == OP_SLL) || (ALUControl == OP_SRL) ||
                       (ALUControl == OP_SRA);
  assign in_ready    = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept      = in_valid && in_ready;
  assign start_shift = accept && is_shift && (shamt != '0);
  assign out_valid   = (state_q == DONE);
  assign ALUResult   = res_q;
  assign Zero        = zero_q;

  // Single-cycle result; shift codes only land here with shamt=0, so they pass SrcA.
  always_comb begin
    alu_res = SrcA + SrcB;
    case (ALUControl)
      OP_SUB:   alu_res = SrcA - SrcB;
      OP_SLL,
      OP_SRL,
      OP_SRA:   alu_res = SrcA;
      OP_SLT:   alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      OP_SLTU:  alu_res = {{(DATA_WIDTH-1){1'b0}}, (SrcA < SrcB)};
      OP_XOR:   alu_res = SrcA ^ SrcB;
      OP_OR:    alu_res = SrcA | SrcB;
      OP_AND:   alu_res = SrcA & SrcB;
      OP_PASSB: alu_res = SrcB;
      default:  alu_res = SrcA + SrcB;
    endcase
  end

  // One-bit step of the serial shifter applied to the accumulator.
  always_comb begin
    shift_step = res_q;
    case (kind_q)
      SH_LL:   shift_step = res_q << 1;
      SH_RL:   shift_step = res_q >> 1;
      default: shift_step = {fill_q, res_q[DATA_WIDTH-1:1]};
    endcase
  end

  // Next-state logic; DONE can accept a new op in the cycle its result is taken.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = start_shift ? SHIFT : DONE;
      end
      SHIFT: begin
        if (cnt_q == SHAMT_WIDTH'(1)) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = accept ? (start_shift ? SHIFT : DONE) : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Result/accumulator, shift counter and Zero; result holds while DONE stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q  <= '0;
      zero_q <= 1'b0;
      cnt_q  <= '0;
      kind_q <= SH_LL;
      fill_q <= 1'b0;
    end else if (accept) begin
      if (start_shift) begin
        res_q  <= SrcA;
        zero_q <= 1'b0;
        cnt_q  <= shamt;
        fill_q <= SrcA[DATA_WIDTH-1];
        kind_q <= (ALUControl == OP_SLL) ? SH_LL :
                  (ALUControl == OP_SRL) ? SH_RL : SH_RA;
      end else begin
        res_q  <= alu_res;
        zero_q <= (alu_res == '0);
      end
    end else if (state_q == SHIFT) begin
      res_q <= shift_step;
      cnt_q <= cnt_q - SHAMT_WIDTH'(1);
      if (cnt_q == SHAMT_WIDTH'(1)) zero_q <= (shift_step == '0);
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: scoreboard bench for seq_alu. The driver pushes the expected
// result when an op is offered; a monitor pops and compares on each handshake.
module tb_seq_alu;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  ALUControl;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ALUResult;
  logic        Zero;

  typedef struct {
    logic [31:0] res;
    logic        zero;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  seq_alu dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ALUControl (ALUControl),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ALUResult  (ALUResult),
    .Zero       (Zero)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkEq(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic pushExp(input logic [31:0] res, input string name);
    exp_t e;
    e.res  = res;
    e.zero = (res == 32'h0);
    e.name = name;
    exp_q.push_back(e);
  endtask

  // Offer an op (called just after a rising edge); returns just after its accept edge.
  task automatic applyStimulus(input logic [3:0] ctrl, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] exp_res,
                               input bit expect_out, input string name);
    int waited = 0;
    ALUControl = ctrl;
    SrcA       = a;
    SrcB       = b;
    in_valid   = 1'b1;
    while (in_ready !== 1'b1 && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    if (waited >= 100) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s accept timeout: got in_ready %b expected 1", name, in_ready);
    end
    if (expect_out) pushExp(exp_res, name);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Counts cycles from the offer cycle (accept edge = 1) until out_valid.
  task automatic waitDone(input int exp_lat, input bit ready_low, input string name);
    int lat = 1;
    bit ready_bad = 1'b0;
    while (out_valid !== 1'b1 && lat < 100) begin
      if (in_ready !== 1'b0) ready_bad = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    checkEq({name, " latency"}, 32'(lat), 32'(exp_lat));
    if (ready_low) checkEq({name, " in_ready low in SHIFT"}, 32'(ready_bad), 32'd0);
  endtask

  // Pops one expectation and compares it with the presented result.
  task automatic checkOutput();
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL unexpected output: got %h expected none", ALUResult);
    end else begin
      e = exp_q.pop_front();
      checkEq({e.name, " result"}, ALUResult, e.res);
      checkEq({e.name, " zero"}, 32'(Zero), 32'(e.zero));
    end
  endtask

  // Monitor: compares on every output handshake, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && out_valid === 1'b1 && out_ready === 1'b1) checkOutput();
    end
  end

  // Directed stimulus.
  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    ALUControl = 4'h0;
    SrcA       = 32'h0;
    SrcB       = 32'h0;
    #1;
    checkEq("reset out_valid", 32'(out_valid), 32'd0);
    checkEq("reset ALUResult", ALUResult, 32'h0);
    checkEq("reset Zero", 32'(Zero), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    checkEq("in_ready after reset", 32'(in_ready), 32'd1);

    // Wrapping adds and single-cycle arithmetic
    applyStimulus(4'b0000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1, "add ovf");
    waitDone(1, 0, "add ovf");
    applyStimulus(4'b0000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1, "add wrap");
    waitDone(1, 0, "add wrap");
    applyStimulus(4'b0001, 32'd5, 32'd5, 32'h0, 1, "sub");
    waitDone(1, 0, "sub");
    applyStimulus(4'b0011, 32'hFFFFFFFF, 32'd1, 32'd1, 1, "slt");
    waitDone(1, 0, "slt");
    applyStimulus(4'b0100, 32'hFFFFFFFF, 32'd1, 32'd0, 1, "sltu");
    waitDone(1, 0, "sltu");
    applyStimulus(4'b1011, 32'hDEADBEEF, 32'h12345000, 32'h12345000, 1, "passb");
    waitDone(1, 0, "passb");
    applyStimulus(4'b1111, 32'd3, 32'd4, 32'd7, 1, "code f add");
    waitDone(1, 0, "code f add");

    // Serial shifts, including the longest and the zero-length case
    applyStimulus(4'b0111, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, "sra 31");
    waitDone(32, 1, "sra 31");
    applyStimulus(4'b0110, 32'h80000000, 32'hFFFFFFFF, 32'h00000001, 1, "srl 31");
    waitDone(32, 1, "srl 31");
    applyStimulus(4'b0010, 32'h00000001, 32'h00000000, 32'h00000001, 1, "sll 0");
    waitDone(1, 0, "sll 0");

    // Back-to-back logic ops with out_ready high
    applyStimulus(4'b0101, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 1, "xor b2b");
    checkEq("xor b2b in_ready", 32'(in_ready), 32'd1);
    checkEq("xor b2b out_valid", 32'(out_valid), 32'd1);
    applyStimulus(4'b1000, 32'h12340000, 32'h00005678, 32'h12345678, 1, "or b2b");
    checkEq("or b2b in_ready", 32'(in_ready), 32'd1);
    checkEq("or b2b out_valid", 32'(out_valid), 32'd1);
    applyStimulus(4'b1001, 32'hFFFF0000, 32'h0F0F0F0F, 32'h0F0F0000, 1, "and b2b");
    checkEq("and b2b in_ready", 32'(in_ready), 32'd1);
    checkEq("and b2b out_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1;

    // Consumer stall: result holds, next op waits for out_ready
    out_ready = 1'b0;
    applyStimulus(4'b0101, 32'hAAAAAAAA, 32'h55555555, 32'hFFFFFFFF, 1, "xor stall");
    ALUControl = 4'b1001;
    SrcA       = 32'hAAAAAAAA;
    SrcB       = 32'h55555555;
    in_valid   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checkEq("stall out_valid", 32'(out_valid), 32'd1);
      checkEq("stall ALUResult", ALUResult, 32'hFFFFFFFF);
      checkEq("stall in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    pushExp(32'h0, "and after stall");
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkEq("and after stall out_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1;

    // Offers during SHIFT are ignored (8-bit srl, junk held for 5 of its cycles)
    applyStimulus(4'b0110, 32'hF0000000, 32'd8, 32'h00F00000, 1, "srl 8");
    ALUControl = 4'b0000;
    SrcA       = 32'd1;
    SrcB       = 32'd2;
    in_valid   = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    waitDone(4, 1, "srl 8 remaining");
    @(posedge clk); #1;

    // Reset three cycles into a shift by 10 discards it
    applyStimulus(4'b0010, 32'd1, 32'd10, 32'h0, 0, "sll 10 aborted");
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    checkEq("mid-shift reset out_valid", 32'(out_valid), 32'd0);
    checkEq("mid-shift reset ALUResult", ALUResult, 32'h0);
    checkEq("mid-shift reset Zero", 32'(Zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    applyStimulus(4'b0000, 32'd2, 32'd3, 32'd5, 1, "add after reset");
    waitDone(1, 0, "add after reset");

    repeat (4) @(posedge clk);
    #1;
    checkEq("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
